// File: rtl/cortez_pkg.sv
// rtl/cortez_pkg.sv - shared FSM encoding and index-width helper for output_argmax
package cortez_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int clog2_floor1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_argmax_if.sv
// rtl/output_argmax_if.sv - lane inputs and classification result bundle
interface output_argmax_if #(
  parameter int NUM_INPUTS  = 1,
  parameter int WIDTH       = 8,
  parameter int CLASS_WIDTH = cortez_pkg::clog2_floor1(NUM_INPUTS)
);
  logic [NUM_INPUTS*WIDTH-1:0] values_in;
  logic [NUM_INPUTS-1:0]       valids_in;
  logic [CLASS_WIDTH-1:0]      class_out;
  logic [WIDTH-1:0]            value_out;
  logic                        valid_out;
  logic                        busy;
  logic                        overrun_out;

  modport master (
    output values_in, valids_in,
    input  class_out, value_out, valid_out, busy, overrun_out
  );

  modport slave (
    input  values_in, valids_in,
    output class_out, value_out, valid_out, busy, overrun_out
  );
endinterface

// File: rtl/output_argmax_lane_capture.sv
// rtl/output_argmax_lane_capture.sv - one lane: value register, sticky capture flag, drop detect
module output_argmax_lane_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid,
  input  logic [WIDTH-1:0] value,
  input  logic             collect,
  input  logic             clear,
  output logic             flag,
  output logic [WIDTH-1:0] data,
  output logic             drop
);
  logic capture;

  // First capture wins; anything else presented on this lane is lost.
  assign capture = valid && collect && !flag;
  assign drop    = valid && !capture;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag <= 1'b0;
      data <= '0;
    end else if (capture) begin
      flag <= 1'b1;
      data <= value;
    end else if (clear) begin
      flag <= 1'b0;
    end
  end
endmodule

// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - gathers per-lane neuron outputs, then scans for the signed maximum
module output_argmax
  import cortez_pkg::*;
#(
  parameter int  NUM_INPUTS  = 1,
  parameter int  WIDTH       = 8,
  parameter int  FRAC_BITS   = 3,
  localparam int CLASS_WIDTH = clog2_floor1(NUM_INPUTS)
) (
  input  logic          clk,
  input  logic          rstn,
  output_argmax_if.slave bus
);
  if (FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_frac
    $error("output_argmax: FRAC_BITS outside 0..WIDTH");
  end

  state_t                 state, state_next;
  logic [NUM_INPUTS-1:0]  flags, drops;
  logic [WIDTH-1:0]       lane_data [NUM_INPUTS];
  logic [CLASS_WIDTH-1:0] idx, best_index, class_r, scan_index;
  logic [WIDTH-1:0]       best_value, value_r, cand, scan_value, lane0_next;
  logic                   valid_r, overrun_r;
  logic                   collect, complete, last_scan, take;

  assign collect = (state == COLLECT);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    output_argmax_lane_capture #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .valid   (bus.valids_in[i]),
      .value   (bus.values_in[i*WIDTH +: WIDTH]),
      .collect (collect),
      .clear   (state == DONE),
      .flag    (flags[i]),
      .data    (lane_data[i]),
      .drop    (drops[i])
    );
  end

  if (NUM_INPUTS > 1) begin : g_cand
    assign cand = lane_data[idx];
  end else begin : g_cand1
    assign cand = lane_data[0];
  end

  // Round completes on the edge that captures the last missing lane, so lane 0
  // may still be on the input bus rather than in its register.
  assign complete   = collect && (&(flags | bus.valids_in));
  assign lane0_next = flags[0] ? lane_data[0] : bus.values_in[WIDTH-1:0];
  assign last_scan  = (idx == CLASS_WIDTH'(NUM_INPUTS - 1));
  assign take       = $signed(cand) > $signed(best_value);
  assign scan_value = take ? cand : best_value;
  assign scan_index = take ? idx : best_index;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (complete) state_next = (NUM_INPUTS > 1) ? SCAN : DONE;
      SCAN:    if (last_scan) state_next = DONE;
      DONE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Result registers load on the edge entering DONE so they are valid with the strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx        <= '0;
      best_index <= '0;
      best_value <= '0;
      class_r    <= '0;
      value_r    <= '0;
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      overrun_r <= |drops;
      case (state)
        COLLECT: if (complete) begin
          best_value <= lane0_next;
          best_index <= '0;
          idx        <= CLASS_WIDTH'(1);
          if (NUM_INPUTS == 1) begin
            class_r <= '0;
            value_r <= lane0_next;
            valid_r <= 1'b1;
          end
        end
        SCAN: begin
          best_value <= scan_value;
          best_index <= scan_index;
          idx        <= idx + CLASS_WIDTH'(1);
          if (last_scan) begin
            class_r <= scan_index;
            value_r <= scan_value;
            valid_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.class_out   = class_r;
  assign bus.value_out   = value_r;
  assign bus.valid_out   = valid_r;
  assign bus.overrun_out = overrun_r;
  assign bus.busy        = (state != COLLECT);
endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - scoreboard bench for output_argmax with 4-lane and 1-lane instances
module tb_output_argmax;
  import cortez_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  output_argmax_if #(.NUM_INPUTS(4), .WIDTH(8)) bus4 ();
  output_argmax_if #(.NUM_INPUTS(1), .WIDTH(8)) bus1 ();

  output_argmax #(.NUM_INPUTS(4), .WIDTH(8), .FRAC_BITS(3)) u4 (.clk(clk), .rstn(rstn), .bus(bus4));
  output_argmax #(.NUM_INPUTS(1), .WIDTH(8), .FRAC_BITS(3)) u1 (.clk(clk), .rstn(rstn), .bus(bus1));

  typedef struct {
    int         cls;
    logic [7:0] val;
    int         at;
  } res_t;

  res_t       q4[$];
  res_t       q1[$];
  int         ov4[$];
  int         ov1[$];
  bit [3:0]   mask4 = '0;
  logic [7:0] vals4 [4];
  int         t4 = -100;
  int         t1 = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Reference: gather lanes (first wins), then argmax with lowest index on ties.
  function automatic void model4(input int e, input bit [3:0] v, input bit [31:0] d);
    bit drop = 0;
    int best = 0;
    if (e > t4 && e <= t4 + 4) begin
      if (v != 0) ov4.push_back(e);
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (mask4[i]) drop = 1;
        else begin
          vals4[i] = d[i*8 +: 8];
          mask4[i] = 1'b1;
        end
      end
    end
    if (drop) ov4.push_back(e);
    if (mask4 == 4'hF) begin
      for (int i = 1; i < 4; i++)
        if ($signed(vals4[i]) > $signed(vals4[best])) best = i;
      q4.push_back(res_t'{best, vals4[best], e + 3});
      t4 = e;
      mask4 = '0;
    end
  endfunction

  function automatic void model1(input int e, input bit v, input bit [7:0] d);
    if (e == t1 + 1) begin
      if (v) ov1.push_back(e);
      return;
    end
    if (v) begin
      q1.push_back(res_t'{0, d, e});
      t1 = e;
    end
  endfunction

  task automatic step(input bit [3:0] v4, input bit [31:0] d4, input bit v1, input bit [7:0] d1);
    @(posedge clk);
    #1;
    bus4.valids_in = v4;
    bus4.values_in = d4;
    bus1.valids_in = v1;
    bus1.values_in = d1;
    model4(cyc + 1, v4, d4);
    model1(cyc + 1, v1, d1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus4.valids_in = '0;
    bus4.values_in = '0;
    bus1.valids_in = '0;
    bus1.values_in = '0;
    q4.delete(); q1.delete(); ov4.delete(); ov1.delete();
    mask4 = '0; t4 = -100; t1 = -100;
    #1;
    check("rst_class4",   bus4.class_out,   0);
    check("rst_value4",   bus4.value_out,   0);
    check("rst_valid4",   bus4.valid_out,   0);
    check("rst_busy4",    bus4.busy,        0);
    check("rst_overrun4", bus4.overrun_out, 0);
    check("rst_value1",   bus1.value_out,   0);
    check("rst_valid1",   bus1.valid_out,   0);
    check("rst_busy1",    bus1.busy,        0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    res_t r;
    bit   eo;
    if (rstn) begin
      if (bus4.valid_out) begin
        if (q4.size() == 0) flag_fail("u4_unexpected_valid");
        else begin
          r = q4.pop_front();
          check("u4_latency", cyc, r.at);
          check("u4_class", bus4.class_out, r.cls);
          check("u4_value", bus4.value_out, r.val);
        end
      end else if (q4.size() != 0 && q4[0].at < cyc) begin
        flag_fail("u4_missing_valid");
        void'(q4.pop_front());
      end
      check("u4_busy", bus4.busy, (cyc >= t4 && cyc <= t4 + 3));
      eo = (ov4.size() != 0 && ov4[0] == cyc);
      if (eo) void'(ov4.pop_front());
      check("u4_overrun", bus4.overrun_out, eo);

      if (bus1.valid_out) begin
        if (q1.size() == 0) flag_fail("u1_unexpected_valid");
        else begin
          r = q1.pop_front();
          check("u1_latency", cyc, r.at);
          check("u1_class", bus1.class_out, r.cls);
          check("u1_value", bus1.value_out, r.val);
        end
      end else if (q1.size() != 0 && q1[0].at < cyc) begin
        flag_fail("u1_missing_valid");
        void'(q1.pop_front());
      end
      check("u1_busy", bus1.busy, (cyc == t1));
      eo = (ov1.size() != 0 && ov1[0] == cyc);
      if (eo) void'(ov1.pop_front());
      check("u1_overrun", bus1.overrun_out, eo);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus4.valids_in = '0;
    bus4.values_in = '0;
    bus1.valids_in = '0;
    bus1.values_in = '0;
    do_reset();

    step(4'hF, {8'h10, 8'h18, 8'hF0, 8'h08}, 1'b0, 8'h0);
    idle(6);

    step(4'b1000, 32'h0, 1'b0, 8'h0);
    idle(1);
    step(4'b0001, 32'h00000020, 1'b0, 8'h0);
    idle(2);
    step(4'b0100, 32'h0, 1'b0, 8'h0);
    idle(3);
    step(4'b0010, 32'h0, 1'b0, 8'h0);
    idle(6);

    step(4'hF, {8'hF8, 8'h80, 8'hF8, 8'hF8}, 1'b0, 8'h0);
    idle(6);

    step(4'b0010, 32'h00001000, 1'b0, 8'h0);
    step(4'b0010, 32'h00007F00, 1'b0, 8'h0);
    step(4'b1101, {8'h01, 8'h06, 8'h00, 8'h05}, 1'b0, 8'h0);
    step(4'b0001, 32'h0000007E, 1'b0, 8'h0);
    idle(4);
    step(4'b0111, {8'h00, 8'h33, 8'h22, 8'h11}, 1'b0, 8'h0);
    idle(6);
    step(4'b1000, 32'h44000000, 1'b0, 8'h0);
    idle(6);

    step(4'hF, {8'h70, 8'h10, 8'h20, 8'h30}, 1'b0, 8'h0);
    do_reset();
    step(4'hF, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b0, 8'h0);
    idle(6);

    step(4'b0, 32'h0, 1'b1, 8'h9C);
    step(4'b0, 32'h0, 1'b1, 8'h11);
    idle(3);

    repeat (400) begin
      bit [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(3) == 0);
      step(v, $urandom, ($urandom_range(2) == 0), 8'($urandom));
    end
    idle(8);

    check("q4_drained",  q4.size(),  0);
    check("q1_drained",  q1.size(),  0);
    check("ov4_drained", ov4.size(), 0);
    check("ov1_drained", ov1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
